// File: rtl/mem_access_unit_if.sv
// Data-memory BRAM port bundle between the MEM stage and the Memory block.
// The MEM stage drives the port as master; the BRAM side is the slave.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_ena;
  logic [3:0]        mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [31:0]       mem_dina;
  logic [31:0]       mem_douta;

  modport master (
    output mem_ena,
    output mem_wea,
    output mem_addra,
    output mem_dina,
    input  mem_douta
  );

  modport slave (
    input  mem_ena,
    input  mem_wea,
    input  mem_addra,
    input  mem_dina,
    output mem_douta
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: BRAM access issue, misalignment detection, MEM/WB register
// and load-data alignment/extension for writeback.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_alu_res,
  input  logic [31:0]       ex_rt_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_w_reg_ena,
  input  logic              ex_wb_sel,
  input  logic              stall,
  input  logic              flush,
  mem_access_unit_if.master mem,
  output logic              wb_valid,
  output logic [31:0]       wb_mem_data,
  output logic [ADDR_W-1:0] wb_alu_res,
  output logic [4:0]        wb_rd,
  output logic              wb_w_reg_ena,
  output logic              wb_wb_sel,
  output logic              wb_exc_adel,
  output logic              wb_exc_ades,
  output logic [ADDR_W-1:0] wb_badvaddr
);

  logic [1:0]  off;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic        issue;
  logic        ld_go;
  logic        st_go;
  logic [3:0]  lanes;
  logic [31:0] st_data;

  logic        ld_pend;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_uns;

  assign off     = ex_alu_res[1:0];
  assign is_byte = (ex_size == 2'b00);
  assign is_half = (ex_size == 2'b01);
  assign is_word = ex_size[1];

  assign mis   = (is_half & off[0]) |
                 (is_word & (off != 2'b00));
  assign issue = ex_valid & ~stall & ~flush & ~rst;
  assign ld_go = issue & ex_mem_rd & ~mis;
  assign st_go = issue & ex_mem_wr & ~mis;

  // Stores replicate the datum across the word; lanes pick the bytes.
  always_comb begin
    lanes   = 4'b0000;
    st_data = ex_rt_data;
    unique case (1'b1)
      is_byte: begin
        lanes   = 4'b0001 << off;
        st_data = {4{ex_rt_data[7:0]}};
      end
      is_half: begin
        lanes   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{ex_rt_data[15:0]}};
      end
      is_word: begin
        lanes   = 4'b1111;
        st_data = ex_rt_data;
      end
    endcase
  end

  assign mem.mem_ena   = ld_go | st_go;
  assign mem.mem_wea   = st_go ? lanes : 4'b0000;
  assign mem.mem_addra = {2'b00, ex_alu_res[ADDR_W-1:2]};
  assign mem.mem_dina  = st_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_alu_res   <= '0;
      wb_rd        <= '0;
      wb_w_reg_ena <= 1'b0;
      wb_wb_sel    <= 1'b0;
      wb_exc_adel  <= 1'b0;
      wb_exc_ades  <= 1'b0;
      wb_badvaddr  <= '0;
      ld_pend      <= 1'b0;
      ld_off       <= '0;
      ld_size      <= '0;
      ld_uns       <= 1'b0;
    end else if (flush || (!stall && !ex_valid)) begin
      wb_valid     <= 1'b0;
      wb_alu_res   <= '0;
      wb_rd        <= '0;
      wb_w_reg_ena <= 1'b0;
      wb_wb_sel    <= 1'b0;
      wb_exc_adel  <= 1'b0;
      wb_exc_ades  <= 1'b0;
      wb_badvaddr  <= '0;
      ld_pend      <= 1'b0;
      ld_off       <= '0;
      ld_size      <= '0;
      ld_uns       <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= issue;
      wb_alu_res   <= ex_alu_res;
      wb_rd        <= ex_rd;
      wb_w_reg_ena <= ex_w_reg_ena & ~(mis & ex_mem_rd);
      wb_wb_sel    <= ex_wb_sel;
      wb_exc_adel  <= issue & ex_mem_rd & mis;
      wb_exc_ades  <= issue & ex_mem_wr & mis;
      wb_badvaddr  <= (mis & (ex_mem_rd | ex_mem_wr))
                      ? ex_alu_res : '0;
      ld_pend      <= ld_go;
      ld_off       <= off;
      ld_size      <= ex_size;
      ld_uns       <= ex_unsigned;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sgn_b;
  logic        ld_sgn_h;

  assign ld_byte  = mem.mem_douta[{ld_off, 3'b000} +: 8];
  assign ld_half  = ld_off[1] ? mem.mem_douta[31:16]
                              : mem.mem_douta[15:0];
  assign ld_sgn_b = ~ld_uns & ld_byte[7];
  assign ld_sgn_h = ~ld_uns & ld_half[15];

  always_comb begin
    wb_mem_data = '0;
    if (ld_pend) begin
      unique case (1'b1)
        (ld_size == 2'b00): wb_mem_data = {{24{ld_sgn_b}}, ld_byte};
        (ld_size == 2'b01): wb_mem_data = {{16{ld_sgn_h}}, ld_half};
        ld_size[1]:         wb_mem_data = mem.mem_douta;
      endcase
    end
  end

endmodule
